cordic_share_arbiter: RTL and testbench

- Shares one cordic_unroll1_var core between NUM_REQ requesters, for example several custom-instruction ports or DMA sample streams.
- Arbitrates round-robin and issues one operation at a time: a one-cycle start pulse, then a wait for done.
- Returns the result to the granted requester with a one-cycle response strobe.
- A watchdog converts a missing done into an error response, so no requester can hang the shared core.

---
 rtl/cordic_share_arbiter.sv | 163 ++++++++++++++++
 tb/tb_cordic_share_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_share_arbiter.sv
// cordic_share_arbiter
//   Time-shares a single cordic_unroll1_var core between NUM_REQ requesters.
//   Round-robin arbitration picks one request. The core then gets a one-cycle
//   start pulse, and the arbiter waits for done. The result goes back to the
//   granted requester with a one-cycle strobe. A watchdog turns a missing done
//   into an error response (rsp_err=1, rsp_data all ones).
//
// Ports
//   clock, aclr          : rising-edge clock, asynchronous active-high reset
//   clk_en               : global enable; all state/outputs hold while low
//   req_valid/req_data   : per-requester request and operand (k at [k*DATA_W +: DATA_W])
//   req_ready            : one-hot accept strobe (combinational, IDLE only)
//   rsp_valid/rsp_data   : one-hot response strobe and result
//   rsp_err              : response was produced by the timeout
//   core_aclr/core_clk_en: reset/enable passed straight through to the core
//   core_start/core_dataa: start pulse and registered operand to the core
//   core_result/core_done: core outputs
//   busy                 : operation in progress (state != IDLE)
//   timeout_cnt          : saturating count of timeouts since reset
module cordic_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                      clock,
    input  logic                      aclr,
    input  logic                      clk_en,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      core_aclr,
    output logic                      core_clk_en,
    output logic                      core_start,
    output logic [DATA_W-1:0]         core_dataa,
    input  logic [DATA_W-1:0]         core_result,
    input  logic                      core_done,
    output logic                      busy,
    output logic [7:0]                timeout_cnt
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [GW-1:0]   rr_ptr;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   pick;
    logic [GW-1:0]   scan;
    logic            found;
    logic [CW-1:0]   wait_cnt;
    logic            wait_expired;

    assign core_aclr    = aclr;
    assign core_clk_en  = clk_en;
    assign wait_expired = (wait_cnt == CW'(TIMEOUT - 1));

    // Round-robin search: the first valid requester at or after rr_ptr.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        scan  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan = GW'((32'(rr_ptr) + i) % NUM_REQ);
            if (!found && req_valid[scan]) begin
                found = 1'b1;
                pick  = scan;
            end
        end
    end

    // State register
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; with clk_en low the state is held
    always_comb begin
        state_next = state;
        if (clk_en) begin
            case (state)
                ST_IDLE:  if (found) state_next = ST_ISSUE;
                ST_ISSUE: state_next = ST_WAIT;   // done deliberately ignored here
                ST_WAIT:  if (core_done || wait_expired) state_next = ST_RESP;
                ST_RESP:  state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        busy      = (state != ST_IDLE);
        req_ready = '0;
        if (state == ST_IDLE && clk_en && !aclr && found) begin
            req_ready = ONE_HOT0 << pick;
        end
    end

    // Registered datapath. Pulses are derived from state_next, so they stretch
    // across frozen cycles together with the state.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            rr_ptr      <= '0;
            grant       <= '0;
            core_start  <= 1'b0;
            core_dataa  <= '0;
            rsp_valid   <= '0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            timeout_cnt <= '0;
            wait_cnt    <= '0;
        end else if (clk_en) begin
            core_start <= (state_next == ST_ISSUE);
            rsp_valid  <= (state_next == ST_RESP) ? (ONE_HOT0 << grant) : '0;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        grant      <= pick;
                        core_dataa <= req_data[int'(pick)*DATA_W +: DATA_W];
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= '0;
                end
                ST_WAIT: begin
                    if (core_done) begin
                        rsp_data <= core_result;
                        rsp_err  <= 1'b0;
                    end else if (wait_expired) begin
                        rsp_data <= '1;
                        rsp_err  <= 1'b1;
                        if (timeout_cnt != 8'hFF) begin
                            timeout_cnt <= timeout_cnt + 8'd1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    rr_ptr <= (grant == GW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_share_arbiter.sv
// Self-checking bench for cordic_share_arbiter. A small behavioural core model
// raises done core_lat cycles after the start cycle (core_lat=0: never), and
// force_done can hold done high independently of the model.
module tb_cordic_share_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;

    logic              clock;
    logic              aclr;
    logic              clk_en;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              rsp_err;
    logic              core_aclr;
    logic              core_clk_en;
    logic              core_start;
    logic [DW-1:0]     core_dataa;
    logic [DW-1:0]     core_result;
    logic              core_done;
    logic              busy;
    logic [7:0]        timeout_cnt;

    int checks   = 0;
    int failures = 0;

    cordic_share_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(64)) dut (
        .clock(clock), .aclr(aclr), .clk_en(clk_en),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .core_aclr(core_aclr), .core_clk_en(core_clk_en),
        .core_start(core_start), .core_dataa(core_dataa),
        .core_result(core_result), .core_done(core_done),
        .busy(busy), .timeout_cnt(timeout_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Core model
    int          core_lat   = 0;
    logic        force_done = 1'b0;
    logic [DW-1:0] res_val  = '0;
    logic        run;
    int          cnt;

    assign core_result = res_val;
    assign core_done   = force_done | (run && core_lat != 0 && cnt == core_lat);

    always @(posedge clock or posedge core_aclr) begin
        if (core_aclr) begin
            run <= 1'b0;
            cnt <= 0;
        end else if (core_clk_en) begin
            if (core_start) begin
                run <= 1'b1;
                cnt <= 1;
            end else if (run) begin
                if (core_done) run <= 1'b0;
                cnt <= cnt + 1;
            end
        end
    end

    task automatic do_reset();
        @(negedge clock);
        aclr = 1'b1; clk_en = 1'b1; req_valid = '0; force_done = 1'b0;
        @(negedge clock);
        @(negedge clock);
        aclr = 1'b0;
    endtask

    // Drives one request and returns what was observed; callers compare.
    task automatic issue_and_wait(input int k, input logic [DW-1:0] operand, input int bound,
                                  output logic [NR-1:0] rdy, output logic st, output int n);
        @(negedge clock);
        req_data[k*DW +: DW] = operand;
        req_valid = 4'b0001 << k;
        #1 rdy = req_ready;
        @(negedge clock);
        st = core_start;
        req_valid = '0;
        n = 0;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clock);
            if (rsp_valid != '0) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        aclr = 1'b1; clk_en = 1'b1; req_valid = '0; req_data = '0;
        repeat (2) @(negedge clock);
        req_valid = '1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        checks++; if (core_start !== 1'b0 || rsp_valid !== 4'b0000 || rsp_err !== 1'b0) begin
            failures++; $display("FAIL reset_pulses start=%b rsp_valid=%b err=%b exp=0/0000/0", core_start, rsp_valid, rsp_err); end
        checks++; if (rsp_data !== 32'h0 || core_dataa !== 32'h0 || timeout_cnt !== 8'h0) begin
            failures++; $display("FAIL reset_data rsp_data=%h dataa=%h tcnt=%0d exp=0", rsp_data, core_dataa, timeout_cnt); end
        checks++; if (core_aclr !== 1'b1 || core_clk_en !== 1'b1) begin
            failures++; $display("FAIL reset_passthru core_aclr=%b core_clk_en=%b exp=1/1", core_aclr, core_clk_en); end
        @(negedge clock);
        aclr = 1'b0; req_valid = '0;
    endtask

    task automatic test_single();
        logic [NR-1:0] rdy; logic st; int n;
        core_lat = 16; res_val = 32'h0000_2D41;
        issue_and_wait(2, 32'h0000_4000, 40, rdy, st, n);
        checks++; if (rdy !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b exp=0100", rdy); end
        checks++; if (st !== 1'b1) begin failures++; $display("FAIL single_start got=%b exp=1", st); end
        checks++; if (core_dataa !== 32'h0000_4000) begin failures++; $display("FAIL single_dataa got=%h exp=00004000", core_dataa); end
        checks++; if (n !== 17) begin failures++; $display("FAIL single_latency got=%0d exp=17", n); end
        checks++; if (rsp_valid !== 4'b0100 || rsp_data !== 32'h0000_2D41 || rsp_err !== 1'b0) begin
            failures++; $display("FAIL single_rsp valid=%b data=%h err=%b exp=0100/00002d41/0", rsp_valid, rsp_data, rsp_err); end
        checks++; if (core_start !== 1'b0) begin failures++; $display("FAIL single_start_len got=%b exp=0", core_start); end
        @(negedge clock);
        checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
            failures++; $display("FAIL single_rsp_end valid=%b busy=%b exp=0000/0", rsp_valid, busy); end
        checks++; if (rsp_data !== 32'h0000_2D41) begin failures++; $display("FAIL single_hold got=%h exp=00002d41", rsp_data); end
    endtask

    task automatic test_round_robin();
        logic got;
        logic [NR-1:0] exp;
        do_reset();
        core_lat = 2;
        req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 12; k++) begin
            got = 1'b0;
            for (int t = 0; t < 20; t++) begin
                if (req_ready != '0) begin got = 1'b1; break; end
                @(negedge clock);
            end
            exp = 4'b0001 << (k % 4);
            checks++; if (!got || req_ready !== exp) begin
                failures++; $display("FAIL rr_grant%0d got=%b exp=%b", k, req_ready, exp); end
            @(negedge clock);
        end
        req_valid = '0;
        for (int t = 0; t < 20 && busy; t++) @(negedge clock);
    endtask

    task automatic test_timeout();
        logic [NR-1:0] rdy; logic st; int n;
        do_reset();
        core_lat = 0;
        issue_and_wait(0, 32'h0000_1000, 80, rdy, st, n);
        checks++; if (rdy !== 4'b0001) begin failures++; $display("FAIL to_ready got=%b exp=0001", rdy); end
        checks++; if (n !== 65) begin failures++; $display("FAIL to_latency got=%0d exp=65", n); end
        checks++; if (rsp_valid !== 4'b0001 || rsp_err !== 1'b1 || rsp_data !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL to_rsp valid=%b err=%b data=%h exp=0001/1/ffffffff", rsp_valid, rsp_err, rsp_data); end
        checks++; if (timeout_cnt !== 8'd1) begin failures++; $display("FAIL to_count got=%0d exp=1", timeout_cnt); end
        @(negedge clock);
        checks++; if (rsp_err !== 1'b1) begin failures++; $display("FAIL to_err_hold got=%b exp=1", rsp_err); end
        core_lat = 3; res_val = 32'h1234_5678;
        issue_and_wait(1, 32'h0000_0200, 20, rdy, st, n);
        checks++; if (rdy !== 4'b0010 || n !== 4) begin
            failures++; $display("FAIL to_next ready=%b lat=%0d exp=0010/4", rdy, n); end
        checks++; if (rsp_err !== 1'b0 || rsp_data !== 32'h1234_5678 || timeout_cnt !== 8'd1) begin
            failures++; $display("FAIL to_next_rsp err=%b data=%h tcnt=%0d exp=0/12345678/1", rsp_err, rsp_data, timeout_cnt); end
    endtask

    task automatic test_clk_en();
        int hi; logic got;
        do_reset();
        core_lat = 4; res_val = 32'hCAFE_0001;
        @(negedge clock);
        req_data[3*DW +: DW] = 32'h0000_0777;
        req_valid = 4'b1000;
        #1;
        checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL ce_ready got=%b exp=1000", req_ready); end
        @(negedge clock);
        hi = core_start ? 1 : 0;
        clk_en = 1'b0; req_valid = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL ce_ready_frozen got=%b exp=0000", req_ready); end
            @(negedge clock);
            if (core_start) hi++;
        end
        clk_en = 1'b1; req_valid = '0;
        checks++; if (hi !== 6) begin failures++; $display("FAIL ce_start_len got=%0d exp=6", hi); end
        @(negedge clock);
        checks++; if (core_start !== 1'b0) begin failures++; $display("FAIL ce_start_end got=%b exp=0", core_start); end
        got = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (rsp_valid != '0) begin got = 1'b1; break; end
            @(negedge clock);
        end
        hi = (rsp_valid == 4'b1000) ? 1 : 0;
        clk_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (rsp_valid == 4'b1000) hi++;
        end
        clk_en = 1'b1;
        checks++; if (!got || hi !== 6) begin failures++; $display("FAIL ce_rsp_len got=%0d exp=6", hi); end
        checks++; if (rsp_data !== 32'hCAFE_0001 || rsp_err !== 1'b0) begin
            failures++; $display("FAIL ce_rsp_data data=%h err=%b exp=cafe0001/0", rsp_data, rsp_err); end
        @(negedge clock);
        @(negedge clock);
        checks++; if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin
            failures++; $display("FAIL ce_no_extra busy=%b valid=%b exp=0/0000", busy, rsp_valid); end
    endtask

    task automatic test_aclr();
        logic [NR-1:0] rdy; logic st; int n;
        do_reset();
        core_lat = 2; res_val = 32'h0000_0011;
        issue_and_wait(1, 32'h0000_0001, 20, rdy, st, n);
        core_lat = 0;
        @(negedge clock);
        req_data[2*DW +: DW] = 32'h0000_0002;
        req_valid = 4'b0100;
        @(negedge clock);
        req_valid = '0;
        repeat (3) @(negedge clock);
        aclr = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || rsp_valid !== 4'b0000 || core_start !== 1'b0 || core_aclr !== 1'b1) begin
            failures++; $display("FAIL aclr_now busy=%b valid=%b start=%b core_aclr=%b exp=0/0000/0/1",
                                 busy, rsp_valid, core_start, core_aclr); end
        @(negedge clock);
        checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL aclr_no_rsp got=%b exp=0000", rsp_valid); end
        aclr = 1'b0; req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL aclr_rrptr got=%b exp=0001", req_ready); end
        req_valid = '0;
        core_lat = 5; res_val = 32'h0BAD_F00D;
        issue_and_wait(1, 32'h0000_3333, 20, rdy, st, n);
        checks++; if (rdy !== 4'b0010 || core_dataa !== 32'h0000_3333) begin
            failures++; $display("FAIL aclr_req1 ready=%b dataa=%h exp=0010/00003333", rdy, core_dataa); end
        checks++; if (n !== 6 || rsp_valid !== 4'b0010 || rsp_data !== 32'h0BAD_F00D || rsp_err !== 1'b0) begin
            failures++; $display("FAIL aclr_rsp lat=%0d valid=%b data=%h err=%b exp=6/0010/0badf00d/0",
                                 n, rsp_valid, rsp_data, rsp_err); end
    endtask

    task automatic test_stale_done();
        logic [NR-1:0] rdy; logic st; int n;
        do_reset();
        core_lat = 2; res_val = 32'h0000_00AA;
        issue_and_wait(0, 32'h0000_0010, 20, rdy, st, n);
        force_done = 1'b1; core_lat = 0;
        req_data[1*DW +: DW] = 32'h0000_0020;
        req_valid = 4'b0010;
        @(negedge clock);
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL stale_ready got=%b exp=0010", req_ready); end
        @(negedge clock);
        checks++; if (core_start !== 1'b1 || rsp_valid !== 4'b0000) begin
            failures++; $display("FAIL stale_issue start=%b valid=%b exp=1/0000", core_start, rsp_valid); end
        force_done = 1'b0; req_valid = '0;
        @(negedge clock);
        checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL stale_ignored got=%b exp=0000", rsp_valid); end
        repeat (2) @(negedge clock);
        checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b1) begin
            failures++; $display("FAIL stale_waiting valid=%b busy=%b exp=0000/1", rsp_valid, busy); end
        force_done = 1'b1; res_val = 32'h5A5A_0003;
        @(negedge clock);
        force_done = 1'b0;
        checks++; if (rsp_valid !== 4'b0010 || rsp_data !== 32'h5A5A_0003 || rsp_err !== 1'b0) begin
            failures++; $display("FAIL stale_rsp valid=%b data=%h err=%b exp=0010/5a5a0003/0", rsp_valid, rsp_data, rsp_err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_clk_en();
        test_aclr();
        test_stale_done();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
